round_robin_arbiter_9: RTL and testbench

//  Shares one resource between 9 requesters using rotating priority. The 9 effective requests are
//  OR-reduced into AnyRequest (a 9-input OR with per-input bubbles), which wakes the arbiter.
//  A registered one-hot Grant is held until the owner releases. Sits between the processor's
//  9 bus masters and the shared datapath/memory port.

---
 rtl/round_robin_arbiter_9.sv | 146 ++++++++++++++
 tb/tb_round_robin_arbiter_9.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/round_robin_arbiter_9.sv
// 9-way round-robin arbiter, registered one-hot grant held until release.
// Optional ARB_TIMEOUT_EN: forced revoke after MaxHold grant cycles.
module round_robin_arbiter_9 #(
  parameter logic [8:0] ReqInvertMask = 9'h000,
  parameter int         MaxHold       = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Tick,
  input  logic [8:0] Request,
  input  logic       Release,
  output logic [8:0] Grant,
  output logic       GrantValid,
  output logic [3:0] GrantIndex,
  output logic       AnyRequest,
  output logic       Timeout
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t     state_q, state_d;
  logic [8:0] grant_q, grant_d;
  logic [3:0] gidx_q, gidx_d;
  logic       gvalid_q, gvalid_d;
  logic [3:0] ptr_q, ptr_d;

  logic [8:0] req_e;
  logic       pick_hit;
  logic [3:0] pick_idx;
  logic [4:0] scan_sum;
  logic [3:0] scan_idx;
  logic [3:0] owner_next;
  logic       rel_cond;

  assign req_e      = Request ^ ReqInvertMask;
  assign AnyRequest = |req_e;
  assign rel_cond   = Release | ~req_e[gidx_q];
  assign owner_next = (gidx_q == 4'd8) ? 4'd0 : gidx_q + 4'd1;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MaxHold) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
  assign Timeout = to_q;
`else
  assign Timeout = 1'b0;
`endif

  // Rotating scan: first effective request at or after the pointer
  always_comb begin
    pick_hit = 1'b0;
    pick_idx = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < 9; k++) begin
      scan_sum = {1'b0, ptr_q} + 5'(k);
      scan_idx = (scan_sum >= 5'd9) ? 4'(scan_sum - 5'd9)
                                    : scan_sum[3:0];
      if (!pick_hit && req_e[scan_idx]) begin
        pick_hit = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    gvalid_d = gvalid_q;
    ptr_d    = ptr_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    to_d     = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pick_hit) begin
          state_d  = S_GRANT;
          grant_d  = 9'b1 << pick_idx;
          gidx_d   = pick_idx;
          gvalid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      S_GRANT: begin
        if (rel_cond) begin
          state_d  = S_IDLE;
          grant_d  = '0;
          gidx_d   = '0;
          gvalid_d = 1'b0;
          ptr_d    = owner_next;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CW'(MaxHold - 1)) begin
          state_d  = S_IDLE;
          grant_d  = '0;
          gidx_d   = '0;
          gvalid_d = 1'b0;
          ptr_d    = owner_next;
          to_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; Tick gates every update, reset overrides Tick
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      gvalid_q <= 1'b0;
      ptr_q    <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q    <= '0;
      to_q     <= 1'b0;
`endif
    end else if (Tick) begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      gvalid_q <= gvalid_d;
      ptr_q    <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      to_q     <= to_d;
`endif
    end
  end

  assign Grant      = grant_q;
  assign GrantValid = gvalid_q;
  assign GrantIndex = gidx_q;

endmodule

// File: tb/tb_round_robin_arbiter_9.sv
// Bench for round_robin_arbiter_9: vector table, directed sequences,
// random traffic against a queue-free behavioural arbiter model.
module tb_round_robin_arbiter_9;

  localparam int MH = 16;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Tick;
  logic [8:0] Request;
  logic       Release;
  logic [8:0] Grant;
  logic       GrantValid;
  logic [3:0] GrantIndex;
  logic       AnyRequest;
  logic       Timeout;

  logic [8:0] req2;
  logic [8:0] g2;
  logic       gv2;
  logic [3:0] gi2;
  logic       any2;
  logic       to2;

  int total = 0;
  int bad   = 0;

  int m_owner;
  int m_ptr;
  int m_cnt;
  bit m_to;

  always #5 Clock = ~Clock;

  round_robin_arbiter_9 #(
    .ReqInvertMask(9'h000),
    .MaxHold(MH)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Tick(Tick),
    .Request(Request),
    .Release(Release),
    .Grant(Grant),
    .GrantValid(GrantValid),
    .GrantIndex(GrantIndex),
    .AnyRequest(AnyRequest),
    .Timeout(Timeout)
  );

  round_robin_arbiter_9 #(
    .ReqInvertMask(9'h001),
    .MaxHold(MH)
  ) u_inv (
    .Clock(Clock),
    .Reset(Reset),
    .Tick(Tick),
    .Request(req2),
    .Release(Release),
    .Grant(g2),
    .GrantValid(gv2),
    .GrantIndex(gi2),
    .AnyRequest(any2),
    .Timeout(to2)
  );

  typedef struct {
    logic       rst;
    logic       tick;
    logic [8:0] req;
    logic       rel;
    logic [8:0] g;
    logic [3:0] idx;
    logic       v;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit tick,
                            input logic [8:0] req, input bit rel);
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
      m_to    = 0;
    end else if (tick) begin
      m_to = 0;
      if (m_owner < 0) begin
        for (int k = 0; k < 9; k++) begin
          if (m_owner < 0 && req[(m_ptr + k) % 9]) begin
            m_owner = (m_ptr + k) % 9;
            m_cnt   = 0;
          end
        end
      end else if (rel || !req[m_owner]) begin
        m_ptr   = (m_owner + 1) % 9;
        m_owner = -1;
      end
`ifdef ARB_TIMEOUT_EN
      else if (m_cnt == MH - 1) begin
        m_ptr   = (m_owner + 1) % 9;
        m_owner = -1;
        m_to    = 1;
      end else begin
        m_cnt++;
      end
`endif
    end
  endtask

  task automatic cycle(input bit rst, input bit tick,
                       input logic [8:0] req, input bit rel);
    int eg;
    @(negedge Clock);
    Reset   = rst;
    Tick    = tick;
    Request = req;
    Release = rel;
    #1;
    chk("any_request", int'(AnyRequest), int'(|req));
    @(posedge Clock);
    model_step(rst, tick, req, rel);
    #1;
    eg = (m_owner < 0) ? 0 : (1 << m_owner);
    chk("grant", int'(Grant), eg);
    chk("grant_valid", int'(GrantValid), int'(m_owner >= 0));
    chk("grant_index", int'(GrantIndex), (m_owner < 0) ? 0 : m_owner);
    chk("timeout", int'(Timeout), int'(m_to));
  endtask

  initial begin
    Reset   = 1'b1;
    Tick    = 1'b1;
    Request = '0;
    Release = 1'b0;
    req2    = '0;
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_to    = 0;

    tbl[0]  = '{1, 1, 9'h1FF, 0, 9'h000, 4'd0, 0};
    tbl[1]  = '{0, 1, 9'h008, 0, 9'h008, 4'd3, 1};
    tbl[2]  = '{0, 1, 9'h008, 1, 9'h000, 4'd0, 0};
    tbl[3]  = '{0, 1, 9'h008, 0, 9'h008, 4'd3, 1};
    tbl[4]  = '{0, 1, 9'h008, 1, 9'h000, 4'd0, 0};
    tbl[5]  = '{0, 1, 9'h003, 0, 9'h001, 4'd0, 1};
    tbl[6]  = '{0, 0, 9'h003, 0, 9'h001, 4'd0, 1};
    tbl[7]  = '{0, 0, 9'h003, 1, 9'h001, 4'd0, 1};
    tbl[8]  = '{0, 1, 9'h003, 1, 9'h000, 4'd0, 0};
    tbl[9]  = '{0, 1, 9'h003, 0, 9'h002, 4'd1, 1};
    tbl[10] = '{0, 1, 9'h001, 0, 9'h000, 4'd0, 0};
    tbl[11] = '{0, 1, 9'h001, 0, 9'h001, 4'd0, 1};
    tbl[12] = '{1, 1, 9'h1FF, 0, 9'h000, 4'd0, 0};
    tbl[13] = '{0, 1, 9'h1FF, 0, 9'h001, 4'd0, 1};

    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].rst, tbl[i].tick, tbl[i].req, tbl[i].rel);
      chk($sformatf("tbl%0d_grant", i), int'(Grant), int'(tbl[i].g));
      chk($sformatf("tbl%0d_index", i), int'(GrantIndex),
          int'(tbl[i].idx));
      chk($sformatf("tbl%0d_valid", i), int'(GrantValid),
          int'(tbl[i].v));
    end

    // Round-robin order with wrap: 0..8 then 0 again
    cycle(1, 1, 9'h1FF, 0);
    for (int n = 0; n < 10; n++) begin
      cycle(0, 1, 9'h1FF, 0);
      chk($sformatf("rr_order%0d", n), int'(GrantIndex), n % 9);
      cycle(0, 1, 9'h1FF, 1);
      chk("rr_dead_cycle", int'(GrantValid), 0);
    end

    // Owner 5 withdraws; next grant wraps from 6 to 0
    cycle(1, 1, 9'h000, 0);
    cycle(0, 1, 9'h020, 0);
    chk("hold5_index", int'(GrantIndex), 5);
    cycle(0, 1, 9'h020, 0);
    chk("hold5_kept", int'(Grant), 9'h020);
    cycle(0, 1, 9'h003, 0);
    chk("withdraw_drop", int'(Grant), 0);
    cycle(0, 1, 9'h003, 0);
    chk("wrap_to_0", int'(GrantIndex), 0);

    // Tick low freezes a pending release
    for (int n = 0; n < 5; n++) begin
      cycle(0, 0, 9'h003, 1);
      chk("freeze_grant", int'(Grant), 9'h001);
    end
    cycle(0, 1, 9'h003, 1);
    chk("thaw_release", int'(Grant), 0);

    // Long hold: forced revoke with the timeout build, else held
    cycle(1, 1, 9'h000, 0);
    for (int n = 0; n < 2 * MH + 4; n++) cycle(0, 1, 9'h100, 0);

    // Inverted-polarity input on the second instance
    req2 = 9'h000;
    #1;
    chk("inv_any_active", int'(any2), 1);
    req2 = 9'h001;
    #1;
    chk("inv_any_idle", int'(any2), 0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
            9'($urandom) & 9'($urandom),
            $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
